// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, frame length and the parity rule
// used by both the device-side transmitter and the host-side receiver.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} ps2_tx_state_t;

  localparam int PS2_FRAME_BITS = 11;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; writes are dropped when full and reads are ignored when empty,
// so a pop never sees data pushed on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_device_tx.sv
// Keyboard-side PS/2 transmitter: buffered bytes go out as 11-bit frames, start bit one cycle
// after the pop; in_ready drops only when the byte buffer is full.
module ps2_device_tx import ps2_pkg::*; #(
  parameter int HALF_PERIOD = 4000,
  parameter int GAP_HALVES  = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        ps2_clk,
  output logic                        ps2_dat,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CW = $clog2(HALF_PERIOD * GAP_HALVES);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(HALF_PERIOD * GAP_HALVES - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  ps2_tx_state_t             state_q;
  logic [CW-1:0]             cnt_q;
  logic [3:0]                bit_q;
  logic [PS2_FRAME_BITS-1:0] sh_q;
  logic                      clk_q;
  logic                      fifo_full, fifo_empty, fifo_pop;
  logic [7:0]                fifo_dout;

  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (in_valid),
    .din_i   (in_data),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // sh_q[0] is the data line itself; ones shift in so the line rests high after the stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '1;
      clk_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (!fifo_empty) begin
          sh_q    <= {1'b1, odd_parity(fifo_dout), fifo_dout, 1'b0};
          bit_q   <= '0;
          cnt_q   <= HALF_LOAD;
          state_q <= HIGH;
        end
        HIGH: if (cnt_q == '0) begin
          clk_q   <= 1'b0;
          cnt_q   <= HALF_LOAD;
          state_q <= LOW;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        LOW: if (cnt_q == '0) begin
          clk_q <= 1'b1;
          if (bit_q == LAST_BIT) begin
            cnt_q   <= GAP_LOAD;
            state_q <= GAP;
          end else begin
            sh_q    <= {1'b1, sh_q[PS2_FRAME_BITS-1:1]};
            bit_q   <= bit_q + 4'd1;
            cnt_q   <= HALF_LOAD;
            state_q <= HIGH;
          end
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        GAP: if (cnt_q == '0) begin
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ps2_clk  = clk_q;
  assign ps2_dat  = sh_q[0];
  assign in_ready = !fifo_full;
  assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule
